// File: rtl/i_writeback.sv
// i_writeback -- MEM/WB pipeline stage.
//
// Latches EX/MEM results and drives the register-file write port used by
// i_decode. Loads issue a data-memory request and either complete in the
// same cycle (zero-wait) or park the stage in WAIT_MEM. While parked, the
// upstream stages are stalled. A load that waits MEM_TIMEOUT cycles is
// abandoned and raises the sticky mem_err flag.
//
// Optional feature macro: WB_RETIRE_CNT_EN adds the retired_count output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   EX_MEM_*              incoming instruction slot (valid, alu_result/address,
//                         rd, reg_write, mem_read, mem_to_reg)
//   flush                 kills the in-flight instruction
//   dmem_ready/dmem_rdata data-memory response
//   dmem_req              load request (combinational, held until ready)
//   mem_stall             upstream must hold EX/MEM (combinational)
//   mem_err               sticky load-timeout flag
//   MEM_WB_rd/_reg_write  register-file write address / enable
//   WB_mux5_write_data    register-file write data
//   retired_count         retired instruction counter (WB_RETIRE_CNT_EN only)
module i_writeback #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_MEM_valid,
  input  logic [DATA_W-1:0] EX_MEM_alu_result,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_reg_write,
  input  logic              EX_MEM_mem_read,
  input  logic              EX_MEM_mem_to_reg,
  input  logic              flush,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [REG_AW-1:0] MEM_WB_rd,
  output logic              MEM_WB_reg_write,
  output logic [DATA_W-1:0] WB_mux5_write_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  // Last WAIT_MEM cycle index before the load is abandoned.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [REG_AW-1:0]   rd_reg, rd_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                err_reg, err_next;
  // Copy of the parked load, so the writeback does not depend on upstream
  // holding its outputs perfectly stable.
  logic [REG_AW-1:0]   p_rd_reg, p_rd_next;
  logic                p_we_reg, p_we_next;
  logic                p_m2r_reg, p_m2r_next;
  logic [DATA_W-1:0]   p_alu_reg, p_alu_next;
  logic                req_c, stall_c, live;

  assign live = EX_MEM_valid & ~flush;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_next    = rd_reg;
    we_next    = 1'b0;
    data_next  = data_reg;
    err_next   = err_reg;
    p_rd_next  = p_rd_reg;
    p_we_next  = p_we_reg;
    p_m2r_next = p_m2r_reg;
    p_alu_next = p_alu_reg;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (live) begin
          if (EX_MEM_mem_read) req_c = 1'b1;
          if (!EX_MEM_mem_read || dmem_ready) begin
            rd_next   = EX_MEM_rd;
            we_next   = EX_MEM_reg_write & (EX_MEM_rd != '0);
            data_next = EX_MEM_mem_to_reg ? dmem_rdata : EX_MEM_alu_result;
          end else begin
            stall_c    = 1'b1;
            state_next = WAIT_MEM;
            p_rd_next  = EX_MEM_rd;
            p_we_next  = EX_MEM_reg_write & (EX_MEM_rd != '0);
            p_m2r_next = EX_MEM_mem_to_reg;
            p_alu_next = EX_MEM_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        req_c = 1'b1;
        if (flush) begin
          // flush beats a simultaneous dmem_ready: the load is dropped.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (dmem_ready) begin
          rd_next    = p_rd_reg;
          we_next    = p_we_reg;
          data_next  = p_m2r_reg ? dmem_rdata : p_alu_reg;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          stall_c  = 1'b1;
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      we_reg    <= 1'b0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
      p_rd_reg  <= '0;
      p_we_reg  <= 1'b0;
      p_m2r_reg <= 1'b0;
      p_alu_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_reg    <= rd_next;
      we_reg    <= we_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
      p_rd_reg  <= p_rd_next;
      p_we_reg  <= p_we_next;
      p_m2r_reg <= p_m2r_next;
      p_alu_reg <= p_alu_next;
    end
  end

  // Combinational outputs are forced low while reset is held so that every
  // output reads 0 during reset regardless of the incoming slot.
  assign dmem_req           = rst_n & req_c;
  assign mem_stall          = rst_n & stall_c;
  assign mem_err            = err_reg;
  assign MEM_WB_rd          = rd_reg;
  assign MEM_WB_reg_write   = we_reg;
  assign WB_mux5_write_data = data_reg;

`ifdef WB_RETIRE_CNT_EN
  logic        retire;
  logic [31:0] ret_cnt_reg;

  // An instruction retires when it leaves the stage without being flushed
  // or timed out, whether or not it writes the register file.
  assign retire = ((state_reg == IDLE) & live & (~EX_MEM_mem_read | dmem_ready))
                | ((state_reg == WAIT_MEM) & ~flush & dmem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ret_cnt_reg <= '0;
    else if (retire) ret_cnt_reg <= ret_cnt_reg + 32'd1;
  end

  assign retired_count = ret_cnt_reg;
`endif

endmodule

// File: tb/tb_i_writeback.sv
module tb_i_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_MEM_valid;
  logic [31:0] EX_MEM_alu_result;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_reg_write;
  logic        EX_MEM_mem_read;
  logic        EX_MEM_mem_to_reg;
  logic        flush;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        mem_stall;
  logic        mem_err;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_reg_write;
  logic [31:0] WB_mux5_write_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i_writeback dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .EX_MEM_valid      (EX_MEM_valid),
    .EX_MEM_alu_result (EX_MEM_alu_result),
    .EX_MEM_rd         (EX_MEM_rd),
    .EX_MEM_reg_write  (EX_MEM_reg_write),
    .EX_MEM_mem_read   (EX_MEM_mem_read),
    .EX_MEM_mem_to_reg (EX_MEM_mem_to_reg),
    .flush             (flush),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .dmem_req          (dmem_req),
    .mem_stall         (mem_stall),
    .mem_err           (mem_err),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_reg_write  (MEM_WB_reg_write),
    .WB_mux5_write_data(WB_mux5_write_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_count     (retired_count)
`endif
  );

  // Inputs change on the falling edge; checks happen 1ns later (comb) or
  // 1ns after the rising edge (registered).
  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic m2r,
                       input logic fl, input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    EX_MEM_valid = v; EX_MEM_alu_result = alu; EX_MEM_rd = rd;
    EX_MEM_reg_write = rw; EX_MEM_mem_read = mr; EX_MEM_mem_to_reg = m2r;
    flush = fl; dmem_ready = rdy; dmem_rdata = rdata;
    #1;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    EX_MEM_valid = 0; EX_MEM_alu_result = 0; EX_MEM_rd = 0; EX_MEM_reg_write = 0;
    EX_MEM_mem_read = 0; EX_MEM_mem_to_reg = 0; flush = 0; dmem_ready = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dmem_req, mem_stall, mem_err, MEM_WB_reg_write} !== 4'b0 || MEM_WB_rd !== 5'd0
        || WB_mux5_write_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b stall=%b err=%b we=%b rd=%0d data=%h required all 0",
               dmem_req, mem_stall, mem_err, MEM_WB_reg_write, MEM_WB_rd, WB_mux5_write_data);
    end
`ifdef WB_RETIRE_CNT_EN
    total++;
    if (retired_count !== 32'd0) begin
      bad++; $display("FAIL reset_count: got %0d required 0", retired_count);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_alu();
    drive(1, 32'hDEADBEEF, 5, 1, 0, 0, 0, 0, 0);
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL alu_comb: req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    edge1();
    total++;
    if (MEM_WB_rd !== 5'd5 || MEM_WB_reg_write !== 1'b1 || WB_mux5_write_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_wb: rd=%0d we=%b data=%h required 5 1 deadbeef",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
    $display("alu: rd=%0d we=%b data=%h", MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h00000011, 7, 1, 0, 0, 0, 0, 0);
    edge1();
    total++;
    if (MEM_WB_rd !== 5'd7 || MEM_WB_reg_write !== 1'b1 || WB_mux5_write_data !== 32'h11) begin
      bad++;
      $display("FAIL b2b_wb: rd=%0d we=%b data=%h required 7 1 00000011",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
    // Bubble: invalid slot, rd and data must hold.
    drive(0, 32'hFFFFFFFF, 9, 1, 0, 0, 0, 0, 0);
    edge1();
    total++;
    if (MEM_WB_reg_write !== 1'b0 || MEM_WB_rd !== 5'd7 || WB_mux5_write_data !== 32'h11) begin
      bad++;
      $display("FAIL bubble_hold: rd=%0d we=%b data=%h required 7 0 00000011",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
`ifdef WB_RETIRE_CNT_EN
    total++;
    if (retired_count !== 32'd2) begin
      bad++; $display("FAIL count_after_alu: got %0d required 2", retired_count);
    end
`endif
    $display("back_to_back: rd=%0d data=%h", MEM_WB_rd, WB_mux5_write_data);
  endtask

  task automatic test_r0();
    drive(1, 32'h00000001, 0, 1, 0, 0, 0, 0, 0);
    edge1();
    total++;
    if (MEM_WB_reg_write !== 1'b0) begin
      bad++; $display("FAIL r0_write: we=%b required 0", MEM_WB_reg_write);
    end
    $display("r0: we=%b", MEM_WB_reg_write);
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 32'h100, 3, 1, 1, 1, 0, 0, 32'hAAAAAAAA);
      else       drive(1, 32'h100, 3, 1, 1, 1, 0, 1, 32'h12345678);
      total++;
      if (dmem_req !== 1'b1) begin
        bad++; $display("FAIL load_req_c%0d: got %b required 1", i, dmem_req);
      end
      if (mem_stall === 1'b1) stalls++;
      edge1();
      if (i < 3) begin
        total++;
        if (MEM_WB_reg_write !== 1'b0) begin
          bad++; $display("FAIL load_bubble_c%0d: we=%b required 0", i, MEM_WB_reg_write);
        end
      end
    end
    total++;
    if (stalls != 3) begin
      bad++; $display("FAIL load_stall_cycles: got %0d required 3", stalls);
    end
    total++;
    if (MEM_WB_rd !== 5'd3 || MEM_WB_reg_write !== 1'b1 || WB_mux5_write_data !== 32'h12345678) begin
      bad++;
      $display("FAIL load_wb: rd=%0d we=%b data=%h required 3 1 12345678",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL load_idle: req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    $display("load_wait: stalls=%0d data=%h", stalls, WB_mux5_write_data);
  endtask

  task automatic test_zero_wait();
    drive(1, 32'h200, 9, 1, 1, 1, 0, 1, 32'hCAFE0001);
    total++;
    if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL zw_comb: req=%b stall=%b required 1 0", dmem_req, mem_stall);
    end
    edge1();
    total++;
    if (MEM_WB_rd !== 5'd9 || MEM_WB_reg_write !== 1'b1 || WB_mux5_write_data !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL zw_wb: rd=%0d we=%b data=%h required 9 1 cafe0001",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
    $display("zero_wait: data=%h", WB_mux5_write_data);
  endtask

  task automatic test_flush();
    // Flush on an ALU op in IDLE: no write, state held.
    drive(1, 32'h55555555, 12, 1, 0, 0, 1, 0, 0);
    edge1();
    total++;
    if (MEM_WB_reg_write !== 1'b0 || MEM_WB_rd !== 5'd9 || WB_mux5_write_data !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL flush_idle: rd=%0d we=%b data=%h required 9 0 cafe0001",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
    // Load parks in WAIT_MEM, then flush arrives together with dmem_ready.
    drive(1, 32'h300, 6, 1, 1, 1, 0, 0, 0);
    edge1();
    drive(1, 32'h300, 6, 1, 1, 1, 1, 1, 32'h0BAD0BAD);
    edge1();
    total++;
    if (MEM_WB_reg_write !== 1'b0 || WB_mux5_write_data !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL flush_wait: we=%b data=%h required 0 cafe0001",
               MEM_WB_reg_write, WB_mux5_write_data);
    end
    drive(1, 32'h00000044, 4, 1, 0, 0, 0, 0, 0);
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL flush_req_drop: req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    edge1();
    total++;
    if (MEM_WB_rd !== 5'd4 || MEM_WB_reg_write !== 1'b1 || WB_mux5_write_data !== 32'h44) begin
      bad++;
      $display("FAIL flush_next_alu: rd=%0d we=%b data=%h required 4 1 00000044",
               MEM_WB_rd, MEM_WB_reg_write, WB_mux5_write_data);
    end
`ifdef WB_RETIRE_CNT_EN
    // alu(2) + r0 + load + zero-wait load + this alu = 6; flushed ones excluded.
    total++;
    if (retired_count !== 32'd6) begin
      bad++; $display("FAIL count_after_flush: got %0d required 6", retired_count);
    end
`endif
    $display("flush: next rd=%0d data=%h", MEM_WB_rd, WB_mux5_write_data);
  endtask

  task automatic test_timeout();
    int edges = 0;
    int writes = 0;
    // One IDLE issue edge plus 16 WAIT_MEM edges before mem_err is seen.
    drive(1, 32'h400, 8, 1, 1, 1, 0, 0, 0);
    while (mem_err !== 1'b1 && edges < 40) begin
      edge1();
      edges++;
      if (MEM_WB_reg_write === 1'b1) writes++;
    end
    total++;
    if (edges != 17) begin
      bad++; $display("FAIL timeout_edges: got %0d required 17", edges);
    end
    total++;
    if (writes != 0) begin
      bad++; $display("FAIL timeout_write: got %0d writes required 0", writes);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL timeout_idle: req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    edge1();
    total++;
    if (mem_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: err=%b required 1", mem_err);
    end
    $display("timeout: edges=%0d err=%b", edges, mem_err);
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h500, 10, 1, 1, 1, 0, 0, 0);
    edge1();
    edge1();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({dmem_req, mem_stall, mem_err, MEM_WB_reg_write} !== 4'b0 || MEM_WB_rd !== 5'd0
        || WB_mux5_write_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: req=%b stall=%b err=%b we=%b rd=%0d data=%h required all 0",
               dmem_req, mem_stall, mem_err, MEM_WB_reg_write, MEM_WB_rd, WB_mux5_write_data);
    end
`ifdef WB_RETIRE_CNT_EN
    total++;
    if (retired_count !== 32'd0) begin
      bad++; $display("FAIL reset_mid_count: got %0d required 0", retired_count);
    end
`endif
    EX_MEM_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL reset_mid_idle: req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    $display("reset_mid: err=%b", mem_err);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_r0();
    test_load_wait();
    test_zero_wait();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
